// File: rtl/aer_in_tx.sv
// aer_in_tx: buffers spike addresses in a FIFO and replays them on the AERIN
//   bundled-data 4-phase bus (AERIN_ADDR/AERIN_REQ/AERIN_ACK).
// Latency: push at cycle t -> ADDR at t+2, REQ at t+2+SETUP_CYCLES.
// Backpressure: EV_READY = !full, with no bypass when full. ACK stalls are waited out indefinitely.
// Ports:
//   CLK, RST                 clock, async active-high reset
//   EV_VALID/EV_ADDR/EV_READY event source push interface
//   FIFO_COUNT               entries held, excluding the event in flight
//   AERIN_ADDR/REQ/ACK       AER bus, ACK is asynchronous and synchronized here
//   BUSY                     FIFO non-empty or handshake in progress
//   TIMEOUT_ERR/CLR_ERR      sticky handshake-timeout flag and its sync clear
module aer_in_tx #(
  parameter int AER_WIDTH       = 12,
  parameter int FIFO_DEPTH      = 16,
  parameter int SETUP_CYCLES    = 1,
  parameter int ACK_SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          EV_VALID,
  input  logic [AER_WIDTH-1:0]          EV_ADDR,
  output logic                          EV_READY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic [AER_WIDTH-1:0]          AERIN_ADDR,
  output logic                          AERIN_REQ,
  input  logic                          AERIN_ACK,
  output logic                          BUSY,
  output logic                          TIMEOUT_ERR,
  input  logic                          CLR_ERR
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_REQ_HI = 2'd2;
  localparam logic [1:0] ST_REQ_LO = 2'd3;

  logic [AER_WIDTH-1:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]                r_wr_ptr;
  logic [AW:0]                r_rd_ptr;
  logic [ACK_SYNC_STAGES-1:0] r_ack_sync;
  logic [1:0]                 r_state;
  logic [SW-1:0]              r_setup_cnt;
  logic [TW-1:0]              r_to_cnt;
  logic [AER_WIDTH-1:0]       r_addr;
  logic                       r_req;
  logic                       r_err;

  logic [1:0]  w_state_nxt;
  logic        w_ack_s;
  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic        w_full;
  logic        w_wait_state;
  logic        w_to_hit;
  logic [AW:0] w_count;

  // Only the synchronized ACK is ever looked at.
  assign w_ack_s = r_ack_sync[ACK_SYNC_STAGES-1];

  // Pointers carry one extra MSB, so the modular difference is the fill level
  // and full/empty are unambiguous.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == (AW+1)'(FIFO_DEPTH));
  assign w_push  = EV_VALID & ~w_full;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A stale ACK still high from a previous transfer blocks a new one.
        if (!w_empty && !w_ack_s) begin
          w_state_nxt = ST_SETUP;
          w_pop       = 1'b1;
        end
      end
      ST_SETUP: begin
        if (r_setup_cnt == '0) w_state_nxt = ST_REQ_HI;
      end
      ST_REQ_HI: begin
        if (w_ack_s) w_state_nxt = ST_REQ_LO;
      end
      ST_REQ_LO: begin
        if (!w_ack_s) begin
          if (!w_empty) begin
            w_state_nxt = ST_SETUP;
            w_pop       = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_wait_state = (r_state == ST_REQ_HI) || (r_state == ST_REQ_LO);
  // Fires on the cycle the phase counter would reach TIMEOUT_CYCLES. The counter
  // saturates afterwards, so one stuck phase flags only once.
  assign w_to_hit = w_wait_state && (w_state_nxt == r_state) &&
                    (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= EV_ADDR;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ack_sync  <= '0;
      r_state     <= ST_IDLE;
      r_setup_cnt <= '0;
      r_to_cnt    <= '0;
      r_addr      <= '0;
      r_req       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ack_sync <= {r_ack_sync[ACK_SYNC_STAGES-2:0], AERIN_ACK};
      r_state    <= w_state_nxt;

      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);

      // The address register is loaded only on a pop, which can only happen
      // while REQ is low, so ADDR never moves under an asserted REQ.
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + (AW+1)'(1);
        r_addr      <= r_mem[r_rd_ptr[AW-1:0]];
        r_setup_cnt <= SW'(SETUP_CYCLES - 1);
      end else if (r_state == ST_SETUP && r_setup_cnt != '0) begin
        r_setup_cnt <= r_setup_cnt - SW'(1);
      end

      if (r_state == ST_SETUP && w_state_nxt == ST_REQ_HI)
        r_req <= 1'b1;
      else if (r_state == ST_REQ_HI && w_state_nxt == ST_REQ_LO)
        r_req <= 1'b0;

      if (!w_wait_state || w_state_nxt != r_state)
        r_to_cnt <= '0;
      else if (r_to_cnt != TW'(TIMEOUT_CYCLES))
        r_to_cnt <= r_to_cnt + TW'(1);

      // Set has priority over clear.
      if (w_to_hit)     r_err <= 1'b1;
      else if (CLR_ERR) r_err <= 1'b0;
    end
  end

  assign EV_READY    = ~w_full;
  assign FIFO_COUNT  = w_count;
  assign AERIN_ADDR  = r_addr;
  assign AERIN_REQ   = r_req;
  assign TIMEOUT_ERR = r_err;
  assign BUSY        = ~w_empty | (r_state != ST_IDLE);

endmodule
